countdown_timer_arbiter: RTL and testbench
==========================================

Name: countdown_timer_arbiter

Overview:
- Shares one down-counter between NUM_REQ requesters.
- Each requester asks for a countdown of N cycles. A round-robin arbiter grants one request at a time, the shared counter loads N and counts down to zero, and a one-cycle done pulse returns to the owner.
- Sits between the control agents and the shared countdown datapath; it is the sequencer that owns that counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 8, counter width; maximum countdown is 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_count  in  NUM_REQ*CNT_W  per-requester countdown value N; slice i = bits [i*CNT_W +: CNT_W].
- req_ready  out  NUM_REQ  one-hot grant/ready; handshake on req_valid[i] & req_ready[i].
- abort  in  1  cancels the countdown in progress.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- busy  out  1  high while the counter is owned.
- cur_owner  out  $clog2(NUM_REQ)  index of the current/last owner.
- cur_count  out  CNT_W  live counter value.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, done=0, busy=0, cur_owner=0, cur_count=0.
  - RR pointer = NUM_REQ-1, so index 0 has highest priority first.
  - req_ready forced 0 while rst is low.
- Reset mid-countdown discards the job; no done is issued.
- FSM states: IDLE, COUNT.
- IDLE:
  - req_ready is combinational: one-hot on the first valid index searching from pointer+1 upward, with wrap.
  - req_ready is all-zero when no request is valid.
  - On handshake at edge t: cur_count<=req_count[i], cur_owner<=i, pointer<=i, busy<=1, state<=COUNT.
- COUNT:
  - req_ready=0 for every requester.
  - If cur_count!=0: cur_count<=cur_count-1.
  - If cur_count==0: done[cur_owner]<=1 for exactly one cycle, busy<=0, state<=IDLE.
- Latency: handshake in cycle t gives done high in cycle t+N+2 only.
  - N=0 gives done at t+2.
  - The next grant can handshake in the same cycle that done is high.
- The counter never underflows or wraps. cur_count holds 0 in IDLE after completion or abort.
- req_count is sampled only at handshake; later changes and req_valid drops are ignored.
- Abort:
  - In COUNT: next edge gives state IDLE, busy 0, cur_count 0, no done.
  - Abort in the same cycle as cur_count==0: abort wins, no done.
  - Abort in IDLE is ignored and does not block a grant.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- The owner may re-request; it has lowest priority next round.

Decomposition:
- Package countdown_arb_pkg:
  - typedef enum logic {IDLE, COUNT} cd_state_t.
  - Function for the one-hot-to-index encode.
- Sub-module rr_arbiter #(NUM_REQ):
  - Purely combinational priority pick from pointer+1 with wrap.
  - Inputs: req, ptr, enable. Outputs: grant one-hot, grant_idx.
- The top holds the FSM, pointer, counter and done register.

Test Plan:
- Reset then single req_valid[2], N=5, handshake cycle t -> cur_count 5..0 over t+1..t+6, done[2] high only at t+7, busy high t+1..t+6.
- N=0 on requester 1 -> done[1] at t+2 only; cur_count stays 0; no underflow to 8'hFF.
- All four valid continuously, N=1 each -> grant order 0,1,2,3,0; each done pulse one-hot, none missed or duplicated.
- Abort asserted when cur_count=3 on owner 0 -> IDLE next cycle, cur_count=0, done never asserted; requester 1 then granted.
- Abort coincident with cur_count==0 -> no done pulse; abort held while IDLE with req_valid[3] -> grant to 3 proceeds normally.
- rst low mid-countdown (cur_count=7, owner 2) -> all outputs 0 asynchronously; after release, index 0 has highest priority and no stale done.

Source files
------------

// File: rtl/countdown_arb_pkg.sv
// ---------------------------------------------------------------------------
// countdown_arb_pkg
//   Shared types and helpers for the countdown timer arbiter.
//   - cd_state_t    : sequencer state (IDLE waits for a grant, COUNT owns the
//                     shared down-counter).
//   - MAX_REQ       : widest requester vector the helpers accept.
//   - onehot_to_idx : one-hot to binary index encoder (OR-reduction form, so
//                     it has no priority chain and no latch risk).
// ---------------------------------------------------------------------------
package countdown_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } cd_state_t;

    localparam int MAX_REQ = 16;

    // Input is expected to be one-hot or zero; zero encodes to index 0.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage : countdown_arb_pkg

// File: rtl/countdown_timer_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Searches upward from ptr+1 with
//   wrap-around and grants the first asserted request.
//
//   Parameters
//     NUM_REQ    number of requesters (2..16)
//   Ports
//     req        in   NUM_REQ        request vector
//     ptr        in   $clog2(NUM_REQ) last granted index (lowest priority)
//     enable     in   1              when low, no grant is issued
//     grant      out  NUM_REQ        one-hot grant (all zero if none)
//     grant_idx  out  $clog2(NUM_REQ) binary index of grant (0 if none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import countdown_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [MAX_REQ-1:0] grant_ext;
    logic [IDX_W-1:0]   idx;
    logic               found;

    // NOTE: every variable written in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Offset 1..NUM_REQ from the pointer; the pointer itself is visited
        // last, which gives the previous owner lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        grant_ext                = '0;
        grant_ext[NUM_REQ-1:0]   = grant;
    end

    assign grant_idx = IDX_W'(onehot_to_idx(grant_ext));

endmodule : rr_arbiter

// File: rtl/countdown_timer_arbiter.sv
// ---------------------------------------------------------------------------
// countdown_timer_arbiter
//   Shares one down-counter between NUM_REQ requesters. A round-robin grant
//   loads the winner's count N, the counter runs down to zero, and a one-cycle
//   done pulse returns to the owner (done is high N+2 cycles after the
//   handshake cycle). abort cancels the job in progress with no done.
//
//   Parameters
//     NUM_REQ    number of requesters (2..16)
//     CNT_W      counter width
//   Ports
//     clk        in   1               clock, rising edge
//     rst        in   1               asynchronous active-low reset
//     req_valid  in   NUM_REQ         per-requester request valid
//     req_count  in   NUM_REQ*CNT_W   slice i = [i*CNT_W +: CNT_W]
//     req_ready  out  NUM_REQ         one-hot grant, only while IDLE
//     abort      in   1               cancel the running countdown
//     done       out  NUM_REQ         one-hot completion pulse
//     busy       out  1               counter is owned
//     cur_owner  out  $clog2(NUM_REQ) current / last owner
//     cur_count  out  CNT_W           live counter value
// ---------------------------------------------------------------------------
module countdown_timer_arbiter
    import countdown_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    localparam int OWN_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [OWN_W-1:0]         cur_owner,
    output logic [CNT_W-1:0]         cur_count
);

    cd_state_t            state, state_nx;
    logic [OWN_W-1:0]     ptr, ptr_nx;
    logic [OWN_W-1:0]     owner_nx;
    logic [CNT_W-1:0]     count_nx;
    logic [NUM_REQ-1:0]   done_nx;

    logic [NUM_REQ-1:0]   grant;
    logic [OWN_W-1:0]     grant_idx;
    logic                 arb_enable;

    logic [CNT_W-1:0]     req_cnt_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_cnt_arr[g] = req_count[g*CNT_W +: CNT_W];
    end

    // Grants are offered only in IDLE; the rst term keeps req_ready low
    // combinationally for the whole time reset is held.
    assign arb_enable = (state == IDLE) && rst;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A non-zero grant already implies req_valid for that index, so grant
    // itself is the handshake.
    assign req_ready = grant;
    assign busy      = (state == COUNT);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = cur_owner;
        count_nx = cur_count;
        done_nx  = '0;

        unique case (state)
            IDLE: begin
                // abort has no effect here, so it cannot block a grant.
                if (|grant) begin
                    count_nx = req_cnt_arr[grant_idx];
                    owner_nx = grant_idx;
                    ptr_nx   = grant_idx;
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    // Abort beats completion even when the count is zero.
                    count_nx = '0;
                    state_nx = IDLE;
                end else if (cur_count != '0) begin
                    count_nx = cur_count - CNT_W'(1);
                end else begin
                    done_nx[cur_owner] = 1'b1;
                    state_nx           = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= OWN_W'(NUM_REQ - 1);
            cur_owner <= '0;
            cur_count <= '0;
            done      <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cur_owner <= owner_nx;
            cur_count <= count_nx;
            done      <= done_nx;
        end
    end

endmodule : countdown_timer_arbiter

// File: tb/tb_countdown_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_arbiter
//   Directed bench for countdown_timer_arbiter (NUM_REQ=4, CNT_W=8).
//   Inputs change and registered outputs are sampled 1 time unit after the
//   rising edge; combinational req_ready is sampled 1 unit after inputs move.
// ---------------------------------------------------------------------------
module tb_countdown_timer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 8;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CNT_W-1:0] req_count;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     abort;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [1:0]               cur_owner;
    logic [CNT_W-1:0]         cur_count;

    int total;
    int bad;

    countdown_timer_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_count (req_count),
        .req_ready (req_ready),
        .abort     (abort),
        .done      (done),
        .busy      (busy),
        .cur_owner (cur_owner),
        .cur_count (cur_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_count(input int idx, input logic [CNT_W-1:0] n);
        req_count[idx*CNT_W +: CNT_W] = n;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_count = '0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (cur_owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", cur_owner); end
        total++; if (cur_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cur_count); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_n5();
        set_count(2, 8'd5);
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        set_count(2, 8'd200);   // ignored after the handshake
        for (int k = 1; k <= 6; k++) begin
            total++; if (cur_count !== 8'(6 - k)) begin bad++; $display("FAIL single_count k=%0d got=%0d want=%0d", k, cur_count, 6 - k); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy k=%0d got=%b want=1", k, busy); end
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_early_done k=%0d got=%b want=0000", k, done); end
            total++; if (cur_owner !== 2'd2) begin bad++; $display("FAIL single_owner k=%0d got=%0d want=2", k, cur_owner); end
            tick();
        end
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done got=%b want=0100", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_width got=%b want=0000", done); end
    endtask

    task automatic test_zero_count();
        set_count(1, 8'd0);
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL zero_ready got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b want=1", busy); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL zero_early_done got=%b want=0000", done); end
        total++; if (cur_count !== 8'd0) begin bad++; $display("FAIL zero_count1 got=%0d want=0", cur_count); end
        tick();
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL zero_done got=%b want=0010", done); end
        total++; if (cur_count !== 8'd0) begin bad++; $display("FAIL zero_count2 got=%0d want=0", cur_count); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL zero_done_width got=%b want=0000", done); end
        total++; if (cur_count !== 8'd0) begin bad++; $display("FAIL zero_underflow got=%0d want=0", cur_count); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [5];
        logic [1:0] prev;
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prev      = 2'd0;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_count(i, 8'd1);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            total++; if (req_ready !== (4'b0001 << exp_order[g])) begin bad++; $display("FAIL rr_grant g=%0d got=%b want_idx=%0d", g, req_ready, exp_order[g]); end
            if (g > 0) begin
                total++; if (done !== (4'b0001 << prev)) begin bad++; $display("FAIL rr_done g=%0d got=%b want_idx=%0d", g, done, prev); end
            end else begin
                total++; if (done !== 4'b0000) begin bad++; $display("FAIL rr_done_first got=%b want=0000", done); end
            end
            tick();
            total++; if (cur_owner !== exp_order[g]) begin bad++; $display("FAIL rr_owner g=%0d got=%0d want=%0d", g, cur_owner, exp_order[g]); end
            total++; if (cur_count !== 8'd1 || done !== 4'b0000 || req_ready !== 4'b0000) begin bad++; $display("FAIL rr_cnt1 g=%0d count=%0d done=%b ready=%b want 1/0000/0000", g, cur_count, done, req_ready); end
            tick();
            total++; if (cur_count !== 8'd0 || done !== 4'b0000) begin bad++; $display("FAIL rr_cnt0 g=%0d count=%0d done=%b want 0/0000", g, cur_count, done); end
            tick();
            prev = exp_order[g];
        end
        req_valid = '0;
        #1;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL rr_last_done got=%b want=0001", done); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle_ready got=%b want=0000", req_ready); end
        tick();
        total++; if (done !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_drain done=%b busy=%b want 0000/0", done, busy); end
    endtask

    task automatic test_abort();
        // Pointer is 0 after the round-robin run; only 0 is valid, so it wins.
        set_count(0, 8'd6);
        set_count(1, 8'd2);
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_grant0 got=%b want=0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL abort_ready_count got=%b want=0000", req_ready); end
        repeat (3) tick();
        total++; if (cur_count !== 8'd3) begin bad++; $display("FAIL abort_pre_count got=%0d want=3", cur_count); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || cur_count !== 8'd0 || done !== 4'b0000) begin bad++; $display("FAIL abort_idle busy=%b count=%0d done=%b want 0/0/0000", busy, cur_count, done); end
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL abort_next_grant got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        total++; if (cur_owner !== 2'd1 || busy !== 1'b1 || cur_count !== 8'd2 || done !== 4'b0000) begin bad++; $display("FAIL abort_owner1 owner=%0d busy=%b count=%0d done=%b want 1/1/2/0000", cur_owner, busy, cur_count, done); end
        tick();
        tick();
        total++; if (cur_count !== 8'd0) begin bad++; $display("FAIL abort_zero_pre got=%0d want=0", cur_count); end
        abort = 1'b1;
        tick();
        total++; if (done !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL abort_at_zero done=%b busy=%b want 0000/0", done, busy); end
        // abort still held in IDLE: must not block requester 3.
        set_count(3, 8'd1);
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL abort_idle_grant got=%b want=1000", req_ready); end
        tick();
        abort     = 1'b0;
        req_valid = '0;
        total++; if (cur_owner !== 2'd3 || busy !== 1'b1 || cur_count !== 8'd1) begin bad++; $display("FAIL abort_owner3 owner=%0d busy=%b count=%0d want 3/1/1", cur_owner, busy, cur_count); end
        tick();
        tick();
        total++; if (done !== 4'b1000) begin bad++; $display("FAIL abort_done3 got=%b want=1000", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_count(2, 8'd9);
        set_count(0, 8'd0);
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b want=0100", req_ready); end
        tick();
        req_valid = 4'b0101;
        tick();
        tick();
        total++; if (cur_count !== 8'd7 || cur_owner !== 2'd2) begin bad++; $display("FAIL rmid_pre count=%0d owner=%0d want 7/2", cur_count, cur_owner); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || cur_count !== 8'd0 || cur_owner !== 2'd0 || done !== 4'b0000 || req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_async busy=%b count=%0d owner=%0d done=%b ready=%b want all 0", busy, cur_count, cur_owner, done, req_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_priority got=%b want=0001", req_ready); end
        tick();
        req_valid = '0;
        total++; if (done !== 4'b0000 || cur_owner !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL rmid_owner0 done=%b owner=%0d busy=%b want 0000/0/1", done, cur_owner, busy); end
        tick();
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL rmid_done0 got=%b want=0001", done); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rmid_stale got=%b want=0000", done); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_n5();
        test_zero_count();
        test_round_robin();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Every stimulus step is a fixed cycle count; this only guards a stuck clock.
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_countdown_timer_arbiter
